// File: rtl/axis_pkt_rx_pkg.sv
// axis_pkg: shared types and constants for the AXI-Stream receive path.
// Holds the input FSM state enum, sideband width and the beat layout.
package axis_pkg;

    localparam int DATA_W  = 32;
    localparam int TUSER_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } rx_state_e;

    typedef struct packed {
        logic [TUSER_W-1:0] tuser;
        logic               tlast;
        logic [DATA_W-1:0]  tdata;
    } axis_beat_t;

endpackage

// File: rtl/axis_pkt_rx_if.sv
// axis_if: one AXI-Stream channel (tdata/tvalid/tready/tlast/tuser).
// The master drives payload and valid; the slave drives ready.
interface axis_if
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
);

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [TUSER_W-1:0]    tuser;

    modport master (
        output tdata, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tuser,
        output tready
    );

endinterface

// File: rtl/axis_pkt_rx_sync_fifo.sv
// axis_sync_fifo: generic first-word-fall-through FIFO.
// Pointers carry one extra MSB so full and empty are told apart on wrap.
module axis_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    // Head entry is shown directly; zero when nothing is stored.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; a simultaneous push and pop leaves level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/axis_pkt_rx.sv
// axis_pkt_rx: AXI-Stream packet receiver with length cap and status.
// Define AXIS_PKT_RX_STATS_EN to build pkt_done/pkt_len/pkt_count.
module axis_pkt_rx
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_W,
    parameter int DEPTH       = 16,
    parameter int MAX_PKT_LEN = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_if.slave                  s,
    axis_if.master                 m,
    output logic                   pkt_done,
    output logic [15:0]            pkt_len,
    output logic [15:0]            pkt_count,
    output logic                   err_oversize,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int          BEAT_W  = DATA_WIDTH + TUSER_W + 1;
    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_LEN);

    rx_state_e         state;
    rx_state_e         state_nx;
    logic [15:0]       beat_cnt;
    logic [15:0]       cnt_nx;
    logic [15:0]       cnt_inc;
    logic [15:0]       len_nx;
    logic              rdy_en;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              force_last;
    logic              complete;
    logic              set_err;
    logic              xfer_in;
    logic [BEAT_W-1:0] wr_beat;
    logic [BEAT_W-1:0] rd_beat;

    // rdy_en keeps tready low until the first edge after reset release.
    assign s.tready = rdy_en && (state == DROP || !full);
    assign xfer_in  = s.tvalid && s.tready;
    assign cnt_inc  = beat_cnt + 16'd1;

    // Packet framing: decide push, forced tlast, completion and next state.
    always_comb begin
        state_nx   = state;
        cnt_nx     = beat_cnt;
        push       = 1'b0;
        force_last = 1'b0;
        complete   = 1'b0;
        set_err    = 1'b0;
        len_nx     = 16'd0;
        unique case (state)
            IDLE: begin
                if (xfer_in) begin
                    push = 1'b1;
                    if (s.tlast || MAX_LEN == 16'd1) begin
                        force_last = (MAX_LEN == 16'd1);
                        complete   = 1'b1;
                        len_nx     = 16'd1;
                        cnt_nx     = 16'd0;
                    end else begin
                        cnt_nx   = 16'd1;
                        state_nx = RECV;
                    end
                end
            end
            RECV: begin
                if (xfer_in) begin
                    push   = 1'b1;
                    cnt_nx = cnt_inc;
                    if (s.tlast) begin
                        complete = 1'b1;
                        len_nx   = cnt_inc;
                        cnt_nx   = 16'd0;
                        state_nx = IDLE;
                    end else if (cnt_inc == MAX_LEN) begin
                        force_last = 1'b1;
                        set_err    = 1'b1;
                        complete   = 1'b1;
                        len_nx     = cnt_inc;
                        cnt_nx     = 16'd0;
                        state_nx   = DROP;
                    end
                end
            end
            DROP: begin
                if (xfer_in && s.tlast)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state, beat counter, ready enable and sticky oversize flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            beat_cnt     <= 16'd0;
            rdy_en       <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            state    <= state_nx;
            beat_cnt <= cnt_nx;
            rdy_en   <= 1'b1;
            if (set_err)
                err_oversize <= 1'b1;
        end
    end

    assign wr_beat = {s.tuser, s.tlast | force_last, s.tdata};
    assign pop     = !empty && m.tready;

    axis_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_beat),
        .pop   (pop),
        .rdata (rd_beat),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign m.tvalid = !empty;
    assign {m.tuser, m.tlast, m.tdata} = rd_beat;

`ifdef AXIS_PKT_RX_STATS_EN
    // Completion status: one-cycle pulse, stored length, wrapping count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_done  <= 1'b0;
            pkt_len   <= 16'd0;
            pkt_count <= 16'd0;
        end else begin
            pkt_done <= complete;
            if (complete) begin
                pkt_len   <= len_nx;
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{complete, len_nx};
    assign pkt_done     = 1'b0;
    assign pkt_len      = 16'd0;
    assign pkt_count    = 16'd0;
`endif

endmodule
